// File: rtl/prog_down_counter.sv
// Programmable down-counter emitting a one-cycle shift strobe on terminal count.
// Optional live counter output port enabled by defining DC_COUNT_OUT_EN.
module prog_down_counter #(
    parameter int CNT_W       = 8,
    parameter int SEL_W       = 3,
    parameter int PRESET_BASE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic             shift,
    output logic             busy,
    output logic             done
`ifdef DC_COUNT_OUT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    // Wide enough that PRESET_BASE << (2**SEL_W - 1) cannot overflow before clamping.
    localparam int EXT_W = CNT_W + (1 << SEL_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] sel_q, sel_q_nxt;
    logic             mode_q, mode_q_nxt;
    logic             shift_nxt;
    logic             done_nxt;

    function automatic logic [CNT_W-1:0] preset(input logic [SEL_W-1:0] k);
        logic [EXT_W-1:0] full;
        logic [EXT_W-1:0] lim;
        lim  = EXT_W'(1) << CNT_W;
        full = EXT_W'(PRESET_BASE) << k;
        if (full > lim) begin
            full = lim;
        end
        return CNT_W'(full - EXT_W'(1));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            mode_q <= 1'b0;
            shift  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel_q  <= sel_q_nxt;
            mode_q <= mode_q_nxt;
            shift  <= shift_nxt;
            done   <= done_nxt;
        end
    end

    // Load wins over enable and terminal count, so a strobe due in the load cycle is dropped.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sel_q_nxt  = sel_q;
        mode_q_nxt = mode_q;
        shift_nxt  = 1'b0;
        done_nxt   = done;
        if (load) begin
            cnt_nxt    = preset(sel);
            sel_q_nxt  = sel;
            mode_q_nxt = mode;
            state_nxt  = RUN;
            done_nxt   = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (cnt != '0) begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end else begin
                            shift_nxt = 1'b1;
                            if (mode_q) begin
                                cnt_nxt = preset(sel_q);
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);

`ifdef DC_COUNT_OUT_EN
    assign count = cnt;
`endif

endmodule

// File: tb/tb_prog_down_counter.sv
// Randomized bench for prog_down_counter against an up-counting period model.
// Also checks the live count port when built with DC_COUNT_OUT_EN.
module tb_prog_down_counter;

    localparam int CNT_W       = 8;
    localparam int SEL_W       = 3;
    localparam int PRESET_BASE = 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             load  = 1'b0;
    logic             en    = 1'b0;
    logic             mode  = 1'b0;
    logic [SEL_W-1:0] sel   = '0;
    logic             shift;
    logic             busy;
    logic             done;
`ifdef DC_COUNT_OUT_EN
    logic [CNT_W-1:0] count;
`endif

    prog_down_counter #(
        .CNT_W      (CNT_W),
        .SEL_W      (SEL_W),
        .PRESET_BASE(PRESET_BASE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (en),
        .mode (mode),
        .sel  (sel),
        .shift(shift),
        .busy (busy),
        .done (done)
`ifdef DC_COUNT_OUT_EN
        ,
        .count(count)
`endif
    );

    always #5 clk = ~clk;

    // Model: counts enabled cycles since the last load/reload; strobe after period+1 of them.
    bit m_run;
    bit m_done;
    bit m_auto;
    bit m_shift;
    int m_period;
    int m_ticks;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int ref_preset(input int k);
        int p;
        p = PRESET_BASE * (1 << k);
        if (p > (1 << CNT_W)) p = 1 << CNT_W;
        return p - 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_done   = 1'b0;
        m_auto   = 1'b0;
        m_shift  = 1'b0;
        m_period = 0;
        m_ticks  = 0;
    endtask

    task automatic model_edge();
        m_shift = 1'b0;
        if (load) begin
            m_period = ref_preset(int'(sel));
            m_auto   = mode;
            m_ticks  = 0;
            m_run    = 1'b1;
            m_done   = 1'b0;
        end else if (m_run && en) begin
            m_ticks++;
            if (m_ticks == m_period + 1) begin
                m_shift = 1'b1;
                m_ticks = 0;
                if (!m_auto) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("shift", int'(shift), int'(m_shift));
        check("busy", int'(busy), int'(m_run));
        check("done", int'(done), int'(m_done));
`ifdef DC_COUNT_OUT_EN
        check("count", int'(count), m_run ? (m_period - m_ticks) : 0);
`endif
    endtask

    task automatic cycle(input bit l, input bit e, input bit md, input int s);
        @(negedge clk);
        load = l;
        en   = e;
        mode = md;
        sel  = SEL_W'(s);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Reset asserted between edges must take effect without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 0);

        // sel=0 auto-reload, R=3, period 4; sel churn without load must not matter
        cycle(1'b1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 21; i++) cycle(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 7)));

        // reset mid-run, then idle with en high: no strobe until load
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 0);

        // sel=2 one-shot, R=15: single strobe then done
        cycle(1'b1, 1'b1, 1'b0, 2);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, 5);

        // sel=7 auto-reload, clamped R=255
        cycle(1'b1, 1'b1, 1'b1, 7);
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'b1, 1'b0, 0);

        // sel=1 auto-reload with a 5-cycle freeze mid-count
        cycle(1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0, 0);

        // load landing exactly on the terminal-count cycle
        cycle(1'b1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 7)));

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
